fp_frexp32: RTL and testbench

Single-precision frexp/ilogb unit: splits an FP32 operand into a significand normalised to [1,2) (returned as an FP32 with biased exponent 127) and an unbiased two's-complement integer exponent. It is the inverse of the scaleb stage in the FPU. For every normal operand, feeding `o` and `xo` back through scaleb reproduces `a`. Subnormals are normalised by a multi-cycle shifter, so the block uses a load/done handshake rather than a fixed pipeline.

---
 rtl/fp_frexp32.sv | 142 ++++++++++++++
 tb/tb_fp_frexp32.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_frexp32.sv
// ============================================================================
// Module   : fp_frexp32
// Brief    : FP32 frexp/ilogb - significand in [1,2) plus unbiased exponent.
//            Define FPFREXP_FASTNORM_EN for single-cycle subnormal normalisation.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fp_frexp32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        ld,
    input  logic [31:0] a,
    output logic        busy,
    output logic        done,
    output logic [31:0] o,
    output logic [31:0] xo,
    output logic        zero,
    output logic        inf,
    output logic        nan
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic signed [9:0] C_E_SUB  = -10'sd126;
    localparam logic signed [9:0] C_BIAS   = 10'sd127;
    localparam logic [31:0]       C_XO_ZERO = 32'h8000_0000;
    localparam logic [31:0]       C_XO_BIG  = 32'h7FFF_FFFF;

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_a;
    logic [23:0]        r_m;
    logic signed [9:0]  r_e;

    logic               w_is_zero;
    logic               w_exp_max;
    logic               w_is_nan;
    logic               w_is_inf;

    assign busy      = (r_state != S_IDLE);
    assign w_is_zero = (r_a[30:23] == 8'd0) && (r_a[22:0] == 23'd0);
    assign w_exp_max = &r_a[30:23];
    assign w_is_nan  = w_exp_max && (|r_a[22:0]);
    assign w_is_inf  = w_exp_max && !(|r_a[22:0]);

`ifdef FPFREXP_FASTNORM_EN
    // Leading-zero count of the 24-bit working significand; the highest set bit wins.
    logic [4:0] w_sh;
    always_comb begin
        w_sh = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (r_m[i]) w_sh = 5'(23 - i);
        end
    end
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (ld) begin
                    w_next = ((a[30:23] == 8'd0) && (a[22:0] != 23'd0)) ? S_NORM : S_FIN;
                end
            end
`ifdef FPFREXP_FASTNORM_EN
            S_NORM:  w_next = S_FIN;
`else
            S_NORM:  w_next = r_m[22] ? S_FIN : S_NORM;
`endif
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (ce) begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a  <= 32'd0;
            r_m  <= 24'd0;
            r_e  <= 10'sd0;
            done <= 1'b0;
            o    <= 32'd0;
            xo   <= 32'd0;
            zero <= 1'b0;
            inf  <= 1'b0;
            nan  <= 1'b0;
        end else if (ce) begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ld) begin
                        r_a <= a;
                        r_m <= {(|a[30:23]), a[22:0]};
                        r_e <= (a[30:23] != 8'd0) ? ($signed({2'b00, a[30:23]}) - C_BIAS)
                                                  : C_E_SUB;
                    end
                end
                S_NORM: begin
`ifdef FPFREXP_FASTNORM_EN
                    r_m <= r_m << w_sh;
                    r_e <= C_E_SUB - $signed({5'd0, w_sh});
`else
                    r_m <= r_m << 1;
                    r_e <= r_e - 10'sd1;
`endif
                end
                S_FIN: begin
                    done <= 1'b1;
                    zero <= w_is_zero;
                    inf  <= w_is_inf;
                    nan  <= w_is_nan;
                    // Specials pass the operand through untouched, NaN payload included.
                    if (w_is_zero || w_exp_max) begin
                        o  <= r_a;
                        xo <= w_is_zero ? C_XO_ZERO : C_XO_BIG;
                    end else begin
                        o  <= {r_a[31], 8'd127, r_m[22:0]};
                        xo <= {{22{r_e[9]}}, r_e};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_frexp32.sv
// ============================================================================
// Module   : tb_fp_frexp32
// Brief    : Scoreboard bench for fp_frexp32 with hand-computed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fp_frexp32;

`ifdef FPFREXP_FASTNORM_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam int RST_WAIT = FAST ? 0 : 10;
    localparam int STALL_AT = FAST ? 0 : 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        ld;
    logic [31:0] a;
    logic        busy;
    logic        done;
    logic [31:0] o;
    logic [31:0] xo;
    logic        zero;
    logic        inf;
    logic        nan;

    fp_frexp32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .ld    (ld),
        .a     (a),
        .busy  (busy),
        .done  (done),
        .o     (o),
        .xo    (xo),
        .zero  (zero),
        .inf   (inf),
        .nan   (nan)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a_in;
        logic [31:0] o;
        logic [31:0] xo;
        logic        zero;
        logic        inf;
        logic        nan;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   edge_n   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic int sub_lat(input int k);
        return FAST ? 3 : (25 - k);
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per freshly produced done pulse.
    always @(posedge clk) begin : mon
        logic ce_s;
        logic rst_s;
        exp_t it;
        ce_s  = ce;
        rst_s = rst_n;
        #1;
        if (done && ce_s && rst_s) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at edge %0d, expected no pending op", edge_n);
            end else begin
                it = sb.pop_front();
                check32($sformatf("o[a=%h]", it.a_in), o, it.o);
                check32($sformatf("xo[a=%h]", it.a_in), xo, it.xo);
                check32($sformatf("flags[a=%h]", it.a_in), {29'd0, zero, inf, nan},
                        {29'd0, it.zero, it.inf, it.nan});
                check32($sformatf("latency_edge[a=%h]", it.a_in), edge_n, it.due);
                check32($sformatf("busy_at_done[a=%h]", it.a_in), 32'(busy), 32'd0);
            end
        end
    end

    // Called at a negedge with the DUT idle; returns one negedge after the accepting edge.
    task automatic issue(input logic [31:0] av, input logic [31:0] ro, input logic [31:0] rxo,
                         input logic z, input logic i, input logic n, input int lat);
        exp_t e;
        e.a_in = av;
        e.o    = ro;
        e.xo   = rxo;
        e.zero = z;
        e.inf  = i;
        e.nan  = n;
        e.due  = edge_n + lat;
        sb.push_back(e);
        a  = av;
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic wait_idle();
        int cnt = 0;
        while (sb.size() != 0 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check32("drain_pending", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic run(input logic [31:0] av, input logic [31:0] ro, input logic [31:0] rxo,
                       input logic z, input logic i, input logic n, input int lat);
        issue(av, ro, rxo, z, i, n, lat);
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ce    = 1'b1;
        ld    = 1'b1;
        a     = 32'h3F80_0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check32("rst_done", 32'(done), 32'd0);
        check32("rst_busy", 32'(busy), 32'd0);
        check32("rst_o", o, 32'd0);
        check32("rst_xo", xo, 32'd0);
        check32("rst_flags", {29'd0, zero, inf, nan}, 32'd0);

        // ld already high as reset releases: first done two edges later.
        rst_n = 1'b1;
        issue(32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2);
        wait_idle();

        run(32'h4049_0FDB, 32'h3FC9_0FDB, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 2);
        run(32'hC120_0000, 32'hBFA0_0000, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 2);
        run(32'h7F7F_FFFF, 32'h3FFF_FFFF, 32'h0000_007F, 1'b0, 1'b0, 1'b0, 2);
        run(32'h0080_0000, 32'h3F80_0000, 32'hFFFF_FF82, 1'b0, 1'b0, 1'b0, 2);

        run(32'h0000_0001, 32'h3F80_0000, 32'hFFFF_FF6B, 1'b0, 1'b0, 1'b0, sub_lat(0));
        run(32'h0040_0000, 32'h3F80_0000, 32'hFFFF_FF81, 1'b0, 1'b0, 1'b0, sub_lat(22));
        run(32'h8000_0003, 32'hBFC0_0000, 32'hFFFF_FF6C, 1'b0, 1'b0, 1'b0, sub_lat(1));

        run(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 2);
        run(32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 2);
        run(32'h7F80_0000, 32'h7F80_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 2);
        run(32'h7F80_0001, 32'h7F80_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 2);
        run(32'hFFC0_0000, 32'hFFC0_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 2);

        // Back-to-back: second ld lands in the done cycle of the first.
        issue(32'h4049_0FDB, 32'h3FC9_0FDB, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 2);
        @(negedge clk);
        issue(32'hC120_0000, 32'hBFA0_0000, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 2);
        wait_idle();

        // ld held high across the whole operation: exactly one result.
        begin
            exp_t e;
            int   lat;
            lat    = sub_lat(0);
            e.a_in = 32'h0000_0001;
            e.o    = 32'h3F80_0000;
            e.xo   = 32'hFFFF_FF6B;
            e.zero = 1'b0;
            e.inf  = 1'b0;
            e.nan  = 1'b0;
            e.due  = edge_n + lat;
            sb.push_back(e);
            a  = 32'h0000_0001;
            ld = 1'b1;
            for (int c = 0; c < lat; c++) begin
                @(negedge clk);
                if (c < lat - 1) check32("busy_while_ld_held", 32'(busy), 32'd1);
            end
            ld = 1'b0;
            wait_idle();
        end

        // Clock-enable stall for 5 edges mid-normalisation.
        issue(32'h0000_0001, 32'h3F80_0000, 32'hFFFF_FF6B, 1'b0, 1'b0, 1'b0, sub_lat(0) + 5);
        repeat (STALL_AT) @(negedge clk);
        ce = 1'b0;
        repeat (5) @(negedge clk);
        ce = 1'b1;
        wait_idle();

        // Reset mid-normalisation drops the operation silently.
        a  = 32'h0000_0001;
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        repeat (RST_WAIT) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check32("midrst_busy", 32'(busy), 32'd0);
        check32("midrst_done", 32'(done), 32'd0);
        check32("midrst_o", o, 32'd0);
        check32("midrst_xo", xo, 32'd0);
        repeat (30) @(negedge clk);
        run(32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
